// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for pio_in_edge_irq.
//
// Bus protocol: there is no valid/ready handshake. A write occurs on every
// rising clk edge where chipselect=1 and write_n=0. readdata is registered
// from the address sampled at each edge, regardless of chipselect. Reads
// have a fixed latency of one cycle and never stall.
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture and a maskable interrupt.
//
// Register map (word address):
//   0 data        RO    sampled input data_in
//   1 reserved          reads 0
//   2 irqmask     RW    interrupt enable per bit
//   3 edgecapture R/W1C latched edges; writing 1 clears a bit
//
// Optional feature: define PIO_IN_SYNC_EN to insert a 2-flop synchroniser on
// every in_port bit. Without it, in_port must already be synchronous to clk.
module pio_in_edge_irq #(
  parameter int WIDTH     = 1,  // 1..32
  parameter int EDGE_TYPE = 0,  // 0 rising, 1 falling, 2 any
  parameter int IRQ_MODE  = 1   // 0 level, 1 edge
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_in_edge_irq_if.slave     avs,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] w1c_mask;
  logic [31:0]      read_mux;
  logic             wr_strobe;

  // Only writedata[WIDTH-1:0] is meaningful; the rest is deliberately dropped.
  logic             unused_wdata;
  assign unused_wdata = ^avs.writedata;

`ifdef PIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  // Two-stage synchroniser bringing asynchronous inputs into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

  assign data_in = sync_q2;
`else
  assign data_in = in_port;
`endif

  assign wr_strobe = avs.chipselect & ~avs.write_n;

  // Per-bit edge select; rise and fall are both relative to last cycle's data_in.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = data_in & ~d_prev;
      1:       edge_det = ~data_in & d_prev;
      default: edge_det = (data_in & ~d_prev) | (~data_in & d_prev);
    endcase
  end

  // Clear mask for the edgecapture register, only on a write to address 3.
  always_comb begin
    w1c_mask = '0;
    if (wr_strobe && (avs.address == 2'd3)) begin
      w1c_mask = avs.writedata[WIDTH-1:0];
    end
  end

  // Previous-sample register used by the edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev <= '0;
    end else begin
      d_prev <= data_in;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_strobe && (avs.address == 2'd2)) begin
      irqmask <= avs.writedata[WIDTH-1:0];
    end
  end

  // Edge capture: new edges are OR'd in after the clear, so a set wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~w1c_mask) | edge_det;
    end
  end

  // Read mux, zero-extended above WIDTH.
  always_comb begin
    read_mux = '0;
    case (avs.address)
      2'd0:    read_mux[WIDTH-1:0] = data_in;
      2'd2:    read_mux[WIDTH-1:0] = irqmask;
      2'd3:    read_mux[WIDTH-1:0] = edgecapture;
      default: read_mux = '0;
    endcase
  end

  // readdata updates every cycle; reads have no side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
    end else begin
      avs.readdata <= read_mux;
    end
  end

  // Interrupt source selected at elaboration.
  always_comb begin
    if (IRQ_MODE == 0) begin
      irq = |(data_in & irqmask);
    end else begin
      irq = |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed testbench for pio_in_edge_irq. Two instances: dut_e (rising
// capture, edge IRQ) and dut_l (any-edge capture, level IRQ), both WIDTH=8.
// Bus tasks start and end on a falling clk edge.
module tb_pio_in_edge_irq;

`ifdef PIO_IN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  pio_in_edge_irq_if bus_e ();
  pio_in_edge_irq_if bus_l ();

  logic [1:0]  addr;
  logic        write_n;
  logic [31:0] wdata;
  logic        cs_e;
  logic        cs_l;
  logic [7:0]  in_e;
  logic [7:0]  in_l;
  logic        irq_e;
  logic        irq_l;

  assign bus_e.address    = addr;
  assign bus_e.write_n    = write_n;
  assign bus_e.writedata  = wdata;
  assign bus_e.chipselect = cs_e;
  assign bus_l.address    = addr;
  assign bus_l.write_n    = write_n;
  assign bus_l.writedata  = wdata;
  assign bus_l.chipselect = cs_l;

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_e (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus_e),
    .in_port (in_e),
    .irq     (irq_e)
  );

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MODE(0)) dut_l (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus_l),
    .in_port (in_l),
    .irq     (irq_l)
  );

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write; takes effect at the rising edge inside this call.
  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    addr    = a;
    wdata   = d;
    write_n = 1'b0;
    cs_e    = ~sel;
    cs_l    = sel;
    @(negedge clk);
    write_n = 1'b1;
    cs_e    = 1'b0;
    cs_l    = 1'b0;
  endtask

  // Address sampled at the next rising edge; readdata captured on the following falling edge.
  task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] d);
    addr    = a;
    write_n = 1'b1;
    cs_e    = ~sel;
    cs_l    = sel;
    @(negedge clk);
    d    = sel ? bus_l.readdata : bus_e.readdata;
    cs_e = 1'b0;
    cs_l = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;

    reset_n = 1'b0;
    addr    = 2'd0;
    write_n = 1'b1;
    wdata   = '0;
    cs_e    = 1'b0;
    cs_l    = 1'b0;
    in_e    = '0;
    in_l    = '0;

    tick(2);
    check("in_reset_readdata", bus_e.readdata, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Reset then idle: all registers read 0, no interrupt.
    for (int a = 0; a < 4; a++) begin
      bus_read(1'b0, a[1:0], rd);
      check($sformatf("reset_read_a%0d", a), rd, 32'h0);
    end
    check("reset_irq_e", irq_e, 1'b0);
    check("reset_irq_l", irq_l, 1'b0);

    // Writes to data and reserved are ignored; upper writedata bits are dropped.
    bus_write(1'b0, 2'd0, 32'h0000_00FF);
    bus_write(1'b0, 2'd1, 32'h0000_00FF);
    bus_read(1'b0, 2'd0, rd);
    check("data_write_ignored", rd, 32'h0);
    bus_read(1'b0, 2'd1, rd);
    check("reserved_reads_0", rd, 32'h0);
    bus_write(1'b0, 2'd2, 32'hFFFF_FF05);
    bus_read(1'b0, 2'd2, rd);
    check("irqmask_truncated", rd, 32'h0000_0005);

    // Rising capture timing: irq asserts exactly SYNC_LAT+1 edges after the change.
    in_e = 8'h05;
    tick(SYNC_LAT);
    check("rise_irq_not_yet", irq_e, 1'b0);
    tick(1);
    check("rise_irq_on_time", irq_e, 1'b1);
    bus_read(1'b0, 2'd0, rd);
    check("data_shows_05", rd, 32'h05);
    bus_read(1'b0, 2'd3, rd);
    check("edgecap_05", rd, 32'h05);

    // Falling edges are not captured in rising mode.
    in_e = 8'h00;
    tick(SYNC_LAT + 2);
    bus_read(1'b0, 2'd3, rd);
    check("edgecap_kept_after_fall", rd, 32'h05);

    // W1C.
    bus_write(1'b0, 2'd3, 32'h01);
    check("w1c1_irq_still", irq_e, 1'b1);
    bus_read(1'b0, 2'd3, rd);
    check("w1c1_edgecap_04", rd, 32'h04);
    bus_write(1'b0, 2'd3, 32'h04);
    check("w1c2_irq_low", irq_e, 1'b0);
    bus_read(1'b0, 2'd3, rd);
    check("w1c2_edgecap_00", rd, 32'h00);

    // Unmasked bit captures but does not interrupt.
    in_e = 8'h02;
    tick(SYNC_LAT + 2);
    bus_read(1'b0, 2'd3, rd);
    check("unmasked_edgecap_02", rd, 32'h02);
    check("unmasked_irq_low", irq_e, 1'b0);
    in_e = 8'h00;
    tick(SYNC_LAT + 2);
    bus_write(1'b0, 2'd3, 32'hFF);
    bus_read(1'b0, 2'd3, rd);
    check("clear_all", rd, 32'h00);

    // Simultaneous set and clear on bit 0: set wins.
    in_e = 8'h01;
    tick(SYNC_LAT);
    bus_write(1'b0, 2'd3, 32'h01);
    check("setclr_irq", irq_e, 1'b1);
    bus_read(1'b0, 2'd3, rd);
    check("setclr_bit0_kept", rd, 32'h01);
    bus_write(1'b0, 2'd3, 32'h01);
    bus_read(1'b0, 2'd3, rd);
    check("plain_clear_bit0", rd, 32'h00);
    check("plain_clear_irq", irq_e, 1'b0);

    // Mask write and edge in the same cycle: both land.
    in_e = 8'h05;
    tick(SYNC_LAT);
    bus_write(1'b0, 2'd2, 32'h04);
    check("mask_and_edge_irq", irq_e, 1'b1);
    bus_read(1'b0, 2'd2, rd);
    check("mask_and_edge_mask", rd, 32'h04);
    bus_read(1'b0, 2'd3, rd);
    check("mask_and_edge_cap", rd, 32'h04);

    // Level mode on dut_l.
    bus_write(1'b1, 2'd2, 32'h80);
    check("level_idle_irq", irq_l, 1'b0);
    in_l = 8'h80;
    tick(SYNC_LAT);
    #1;
    check("level_irq_high", irq_l, 1'b1);
    tick(1);
    bus_read(1'b1, 2'd3, rd);
    check("level_rise_cap", rd, 32'h80);
    bus_read(1'b1, 2'd0, rd);
    check("level_data_80", rd, 32'h80);
    bus_write(1'b1, 2'd3, 32'h80);
    check("level_irq_after_w1c", irq_l, 1'b1);
    in_l = 8'h00;
    tick(SYNC_LAT);
    #1;
    check("level_irq_low", irq_l, 1'b0);
    tick(1);
    bus_read(1'b1, 2'd3, rd);
    check("level_fall_cap", rd, 32'h80);
    in_l = 8'h01;
    tick(SYNC_LAT + 1);
    check("level_unmasked_bit", irq_l, 1'b0);

    // Reset mid-operation with irqmask=0xFF, edgecapture=0x3C.
    in_e = 8'h00;
    tick(SYNC_LAT + 2);
    bus_write(1'b0, 2'd3, 32'hFF);
    bus_write(1'b0, 2'd2, 32'hFF);
    in_e = 8'h3C;
    tick(SYNC_LAT + 2);
    bus_read(1'b0, 2'd3, rd);
    check("pre_reset_cap_3c", rd, 32'h3C);
    check("pre_reset_irq", irq_e, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq_e", irq_e, 1'b0);
    check("async_reset_readdata", bus_e.readdata, 32'h0);
    check("async_reset_irq_l", irq_l, 1'b0);
    in_e = 8'h00;
    in_l = 8'h00;
    #1;
    reset_n = 1'b1;
    tick(1);
    bus_read(1'b0, 2'd2, rd);
    check("post_reset_mask", rd, 32'h0);
    bus_read(1'b0, 2'd3, rd);
    check("post_reset_cap", rd, 32'h0);
    bus_read(1'b1, 2'd2, rd);
    check("post_reset_mask_l", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
